// File: rtl/eq_gain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : eq_gain_sequencer
//  Description : Holds per-band target and current EQ gains. On each audio
//                frame it scans all bands, steps each current gain toward its
//                target (ramped +/-1 or jumped) and issues one registered DSP
//                write strobe per changed band.
//  Revision    : 1.0  initial release
// ============================================================================
module eq_gain_sequencer #(
  parameter int NBAND = 7,
  parameter int GW    = 16,
  parameter int GMAX  = 12,
  parameter int GMIN  = -12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame,
  input  logic                 i_req,
  input  logic [2:0]           i_req_band,
  input  logic signed [GW-1:0] i_req_gain,
  input  logic                 i_clear,
  input  logic                 i_ramp_en,
  output logic                 o_ack,
  output logic                 o_wr_en,
  output logic [2:0]           o_wr_band,
  output logic signed [GW-1:0] o_wr_gain,
  output logic                 o_busy
);

  localparam logic [2:0]           LAST_IDX = 3'(NBAND - 1);
  localparam logic signed [GW-1:0] GMAX_V   = GW'(GMAX);
  localparam logic signed [GW-1:0] GMIN_V   = GW'(GMIN);
  localparam logic signed [GW-1:0] ONE_V    = GW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic signed [GW-1:0]  tgt_q [NBAND];
  logic signed [GW-1:0]  tgt_d [NBAND];
  logic signed [GW-1:0]  cur_q [NBAND];
  logic signed [GW-1:0]  cur_d [NBAND];
  logic                  ack_q, ack_d;
  logic                  wr_en_q, wr_en_d;
  logic [2:0]            wr_band_q, wr_band_d;
  logic signed [GW-1:0]  wr_gain_q, wr_gain_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic signed [GW-1:0]  req_gain_clamped;
  logic signed [GW-1:0]  eval_tgt;
  logic signed [GW-1:0]  eval_cur;
  logic signed [GW-1:0]  eval_new;
  logic                  any_diff;

  // Request qualification and target clamping.
  always_comb begin
    accept = i_req && !ack_q && !i_clear;
    if (i_req_gain > GMAX_V) begin
      req_gain_clamped = GMAX_V;
    end else if (i_req_gain < GMIN_V) begin
      req_gain_clamped = GMIN_V;
    end else begin
      req_gain_clamped = i_req_gain;
    end
  end

  // Next-state logic: target updates, scan sequencing and strobe generation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    ack_d     = accept;
    wr_en_d   = 1'b0;
    wr_band_d = wr_band_q;
    wr_gain_d = wr_gain_q;

    // Clear wins over a same-cycle request; the request is retried later.
    for (int b = 0; b < NBAND; b++) begin
      if (i_clear) begin
        tgt_d[b] = '0;
      end else if (accept && (i_req_band == 3'(b))) begin
        tgt_d[b] = req_gain_clamped;
      end
    end

    // Evaluation always uses the registered target, so a same-cycle write
    // only takes effect on the following scan.
    eval_tgt = tgt_q[idx_q];
    eval_cur = cur_q[idx_q];
    if (!i_ramp_en) begin
      eval_new = eval_tgt;
    end else if (eval_tgt > eval_cur) begin
      eval_new = eval_cur + ONE_V;
    end else begin
      eval_new = eval_cur - ONE_V;
    end

    any_diff = 1'b0;
    for (int b = 0; b < NBAND; b++) begin
      if (cur_q[b] != tgt_q[b]) begin
        any_diff = 1'b1;
      end
    end
    busy_d = (state_q == SCAN) || any_diff;

    case (state_q)
      IDLE: begin
        if (i_frame) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (eval_cur != eval_tgt) begin
          cur_d[idx_q] = eval_new;
          wr_en_d      = 1'b1;
          wr_band_d    = idx_q;
          wr_gain_d    = eval_new;
        end
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          // A frame arriving on the last band cycle also queues a rescan.
          if (pend_q || i_frame) begin
            pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 3'd1;
          if (i_frame) begin
            pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_band_q <= '0;
      wr_gain_q <= '0;
      busy_q    <= 1'b0;
      for (int b = 0; b < NBAND; b++) begin
        tgt_q[b] <= '0;
        cur_q[b] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_band_q <= wr_band_d;
      wr_gain_q <= wr_gain_d;
      busy_q    <= busy_d;
      for (int b = 0; b < NBAND; b++) begin
        tgt_q[b] <= tgt_d[b];
        cur_q[b] <= cur_d[b];
      end
    end
  end

  assign o_ack     = ack_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_band = wr_band_q;
  assign o_wr_gain = wr_gain_q;
  assign o_busy    = busy_q;

endmodule
`default_nettype wire

// File: doc/eq_gain_sequencer.md
# eq_gain_sequencer

Sequences equalizer gain updates from the menu FSM into the DSP band-gain registers. Holds a per-band target and current gain. Once per audio sample frame, it steps each current gain toward its target and issues one write strobe per changed band, so gain edits are applied only at sample boundaries and ramp without zipper noise. It sits between the UI state machine (requester) and the DSP gain inputs, all in the BCLK domain.

## Interface
- NBAND, 7: number of bands; band indices 0..NBAND-1
- GW, 16: gain width, two's complement
- GMAX, 12: upper clamp for target gain
- GMIN, -12: lower clamp for target gain

- i_clk  in  1  BCLK; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_frame  in  1  one-cycle sample-boundary pulse (ADC done)
- i_req  in  1  gain-change request; held until o_ack seen
- i_req_band  in  3  band index for request
- i_req_gain  in  GW  requested target gain, signed
- i_clear  in  1  one-cycle pulse: all targets := 0
- i_ramp_en  in  1  1: step ±1 per frame; 0: jump to target in one frame
- o_ack  out  1  one-cycle request acknowledge
- o_wr_en  out  1  one-cycle DSP gain write strobe
- o_wr_band  out  3  band being written
- o_wr_gain  out  GW  new current gain for o_wr_band
- o_busy  out  1  some band current != target, or scan in progress

## Operation
- Storage: tgt[NBAND], cur[NBAND], GW bits each, signed.
- States: IDLE, SCAN. Index counter idx (0..NBAND-1). Flag pend.
- Request accept: in any state, if i_req=1, o_ack=0, and i_clear=0, the block samples the request.
  - If i_req_band < NBAND: tgt[band] := clamp(i_req_gain, GMIN, GMAX).
  - If band >= NBAND: no storage change.
  - o_ack=1 the next cycle in both cases.
- i_clear: all tgt := 0 at that edge. It takes priority over i_req in the same cycle: the request is not acked that cycle and is accepted on the next eligible cycle. cur is untouched; it ramps to 0 via scans.
- IDLE -> SCAN when i_frame=1; idx := 0.
- SCAN, each cycle, evaluate band idx:
  - If cur != tgt and i_ramp_en=1: cur := cur ± 1 toward tgt.
  - If cur != tgt and i_ramp_en=0: cur := tgt.
  - In either case, issue a write strobe with the new cur value.
  - If cur == tgt: no strobe.
- After idx = NBAND-1: if pend, clear pend, idx := 0, stay in SCAN. Otherwise go to IDLE.
- i_frame during SCAN sets pend; further frames while pend=1 are dropped.
- A target written in the same cycle its band is evaluated is not seen by that evaluation; the old tgt is used. The new value applies on the next scan.
- Arithmetic: compare signed; the step never overshoots. Clamped targets guarantee no overflow.

## Timing
- Reset values: o_ack=0, o_wr_en=0, o_wr_band=0, o_wr_gain=0, o_busy=0. All tgt/cur = 0, state IDLE, idx=0, pend=0.
- Reset asserted mid-scan: the next cycle shows o_wr_en=0 and IDLE. No partial strobes follow.
- i_req sampled at edge N: tgt updated at edge N, o_ack high in cycle N+1 only. A request still high in N+2 is accepted again; the requester drops i_req on seeing o_ack.
- i_frame sampled at edge F: band k is evaluated in cycle F+1+k. The registered strobe appears in cycle F+2+k, single cycle, with o_wr_band=k and o_wr_gain = new cur[k].
- Scan length is NBAND cycles. At most NBAND strobes per frame, at most one per band.
- o_busy is registered and reflects state/cur/tgt of the previous cycle.
- Frames must be spaced more than NBAND cycles apart for lossless ramping (BCLK frames are ≥32 cycles).

## Test plan
- Reset, then i_req band=2 gain=5, ramp_en=1, then 6 frames. Expect o_ack one cycle after request. Frames 1-5 each produce one strobe on band 2 with gain 1,2,3,4,5. Frame 6 produces no strobe, and o_busy=0 after frame 5's scan.
- i_req band=1 gain=40. Expect tgt clamped to 12. With ramp_en=0, one frame gives a single strobe band=1 gain=12.
- tgt[0]=3, tgt[4]=-2 (ramp_en=0), then one frame. Expect strobes band 0 at F+2 (gain 3) and band 4 at F+6 (gain -2); no other strobes.
- i_clear and i_req (band 3, gain 7) in the same cycle. Expect no ack that cycle, ack the following cycle, and final tgt[3]=7 with all other targets 0.
- i_req band=7. Expect o_ack and no strobes on subsequent frames.
- Second i_frame two cycles into a scan. Expect the scan to restart right after band NBAND-1 with no IDLE gap. A third frame during the first scan is dropped. Asserting i_rst mid-scan gives no strobe the next cycle and all outputs at reset values.
